// File: rtl/fb_scan_arbiter.sv
// -----------------------------------------------------------------------------
// fb_scan_arbiter
//
// Shares one single-port synchronous framebuffer RAM between the display
// scanline fetcher and a CPU. A line_req pulse starts a burst of LINE_WORDS
// reads from line_base upward. The address wraps modulo 2^ADDR_W. Each
// returned word is written into the line buffer one cycle after it is read.
// During a burst the CPU gets one RAM slot after every SLICE scan reads, but
// only if it is requesting at that point. Outside a burst the CPU is served
// whenever it asks, and a new line_req always wins over the CPU.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   line_req/line_base  start a scanline fetch at line_base
//   line_done           pulses together with the write of the last word
//   line_overrun        pulses when line_req arrives while a fetch is active
//   cpu_req_*           CPU request (valid/ready, we, addr, wdata)
//   cpu_rsp_*           CPU response, one cycle after the grant
//   ram_*               single-port RAM, read data valid the next cycle
//   pix_wr_*            line-buffer write port
// -----------------------------------------------------------------------------
module fb_scan_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 160,
   parameter int SLICE      = 16,
   localparam int IDX_W     = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_req,
   input  logic [ADDR_W-1:0] line_base,
   output logic              line_done,
   output logic              line_overrun,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rsp_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              pix_wr_en,
   output logic [IDX_W-1:0]  pix_wr_idx,
   output logic [DATA_W-1:0] pix_wr_data
);

   // Wide enough to hold SLICE-1 even when SLICE is 1.
   localparam int SLICE_W = $clog2(SLICE + 1);

   typedef enum logic [1:0] {IDLE, SCAN, CPU} state_t;

   state_t             state_reg;
   logic [ADDR_W-1:0]  base_reg;
   logic [IDX_W-1:0]   word_cnt_reg;
   logic [SLICE_W-1:0] slice_cnt_reg;
   logic               in_burst_reg;   // current CPU slot was taken from inside a burst
   logic               pix_en_reg;
   logic [IDX_W-1:0]   pix_idx_reg;
   logic               done_reg;
   logic               rsp_valid_reg;
   logic               rsp_read_reg;

   logic last_read;
   logic slice_end;

   assign last_read = (word_cnt_reg == IDX_W'(LINE_WORDS - 1));
   assign slice_end = (slice_cnt_reg == SLICE_W'(SLICE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         base_reg      <= '0;
         word_cnt_reg  <= '0;
         slice_cnt_reg <= '0;
         in_burst_reg  <= 1'b0;
         pix_en_reg    <= 1'b0;
         pix_idx_reg   <= '0;
         done_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_read_reg  <= 1'b0;
      end else begin
         pix_en_reg    <= 1'b0;
         done_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (line_req) begin
                  base_reg      <= line_base;
                  word_cnt_reg  <= '0;
                  slice_cnt_reg <= '0;
                  state_reg     <= SCAN;
               end else if (cpu_req_valid) begin
                  in_burst_reg <= 1'b0;
                  state_reg    <= CPU;
               end
            end
            SCAN: begin
               // The read issued this cycle lands in the line buffer next cycle.
               pix_en_reg   <= 1'b1;
               pix_idx_reg  <= word_cnt_reg;
               done_reg     <= last_read;
               word_cnt_reg <= word_cnt_reg + 1'b1;
               if (last_read) begin
                  // The final read takes precedence over a slice boundary; a
                  // waiting CPU is then picked up from IDLE.
                  state_reg <= IDLE;
               end else if (slice_end) begin
                  slice_cnt_reg <= '0;
                  if (cpu_req_valid) begin
                     in_burst_reg <= 1'b1;
                     state_reg    <= CPU;
                  end
               end else begin
                  slice_cnt_reg <= slice_cnt_reg + 1'b1;
               end
            end
            CPU: begin
               rsp_valid_reg <= 1'b1;
               rsp_read_reg  <= ~cpu_req_we;
               if (in_burst_reg) begin
                  state_reg <= SCAN;
               end else if (line_req) begin
                  base_reg      <= line_base;
                  word_cnt_reg  <= '0;
                  slice_cnt_reg <= '0;
                  state_reg     <= SCAN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // The RAM port is a pure decode of the arbiter state. Every output is
   // forced low while rst_n is low, even before the first reset edge.
   always_comb begin
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_addr      = '0;
      ram_wdata     = '0;
      cpu_req_ready = 1'b0;
      line_overrun  = 1'b0;
      pix_wr_en     = 1'b0;
      pix_wr_idx    = '0;
      pix_wr_data   = '0;
      line_done     = 1'b0;
      cpu_rsp_valid = 1'b0;
      cpu_rsp_rdata = '0;
      if (rst_n) begin
         case (state_reg)
            SCAN: begin
               ram_en   = 1'b1;
               ram_addr = base_reg + ADDR_W'(word_cnt_reg);
            end
            CPU: begin
               cpu_req_ready = 1'b1;
               ram_en        = 1'b1;
               ram_we        = cpu_req_we;
               ram_addr      = cpu_req_addr;
               ram_wdata     = cpu_req_wdata;
            end
            default: ;
         endcase
         line_overrun  = line_req && ((state_reg == SCAN) ||
                                      ((state_reg == CPU) && in_burst_reg));
         pix_wr_en     = pix_en_reg;
         pix_wr_idx    = pix_en_reg ? pix_idx_reg : '0;
         pix_wr_data   = pix_en_reg ? ram_rdata : '0;
         line_done     = done_reg;
         cpu_rsp_valid = rsp_valid_reg;
         cpu_rsp_rdata = (rsp_valid_reg && rsp_read_reg) ? ram_rdata : '0;
      end
   end

endmodule
